// File: rtl/ecap5_dproc_pkg.sv
// Shared constants for the ECAP5-DPROC pipeline: ALU operation and branch
// condition encodings used by both decode and execute.
package ecap5_dproc_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SHR  = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    localparam logic [2:0] NO_BRANCH     = 3'b000;
    localparam logic [2:0] BRANCH_UNCOND = 3'b001;
    localparam logic [2:0] BRANCH_BEQ    = 3'b010;
    localparam logic [2:0] BRANCH_BNE    = 3'b011;
    localparam logic [2:0] BRANCH_BLT    = 3'b100;
    localparam logic [2:0] BRANCH_BGE    = 3'b101;
    localparam logic [2:0] BRANCH_BLTU   = 3'b110;
    localparam logic [2:0] BRANCH_BGEU   = 3'b111;

endpackage

// File: rtl/alu.sv
// Combinational ALU of the execute stage; ops follow the RV32I funct3 encoding.
module alu
    import ecap5_dproc_pkg::*;
(
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic [2:0]  op_i,
    input  logic        sub_i,
    input  logic        shift_left_i,
    input  logic        signed_shift_i,
    output logic [31:0] result_o
);

    logic [4:0]  shamt;
    logic [31:0] shift_right;

    assign shamt = op2_i[4:0];

    always_comb begin
        if (signed_shift_i) begin
            shift_right = 32'($signed(op1_i) >>> shamt);
        end else begin
            shift_right = op1_i >> shamt;
        end
    end

    always_comb begin
        result_o = '0;
        unique case (op_i)
            ALU_ADD:  result_o = sub_i ? (op1_i - op2_i) : (op1_i + op2_i);
            ALU_SLL,
            ALU_SHR:  result_o = shift_left_i ? (op1_i << shamt) : shift_right;
            ALU_SLT:  result_o = {31'd0, $signed(op1_i) < $signed(op2_i)};
            ALU_SLTU: result_o = {31'd0, op1_i < op2_i};
            ALU_XOR:  result_o = op1_i ^ op2_i;
            ALU_OR:   result_o = op1_i | op2_i;
            ALU_AND:  result_o = op1_i & op2_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/execute.sv
// Execute stage: ALU, branch evaluation and the output pipeline register with
// valid/ready handshakes on both sides and a one-cycle redirect pulse.
module execute
    import ecap5_dproc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,

    output logic        input_ready_o,
    input  logic        input_valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] alu_operand1_i,
    input  logic [31:0] alu_operand2_i,
    input  logic [2:0]  alu_op_i,
    input  logic        alu_sub_i,
    input  logic        alu_shift_left_i,
    input  logic        alu_signed_shift_i,
    input  logic [2:0]  branch_cond_i,
    input  logic [19:0] branch_offset_i,
    input  logic        reg_write_i,
    input  logic [4:0]  reg_addr_i,
    input  logic        ls_enable_i,
    input  logic        ls_write_i,
    input  logic [31:0] ls_write_data_i,
    input  logic [3:0]  ls_sel_i,
    input  logic        ls_unsigned_load_i,

    input  logic        output_ready_i,
    output logic        output_valid_o,
    output logic [31:0] result_o,
    output logic        reg_write_o,
    output logic [4:0]  reg_addr_o,
    output logic        ls_enable_o,
    output logic        ls_write_o,
    output logic [31:0] ls_write_data_o,
    output logic [3:0]  ls_sel_o,
    output logic        ls_unsigned_load_o,
    output logic        branch_o,
    output logic [31:0] branch_target_o
);

    logic [31:0] alu_result;
    logic        taken;
    logic        eq, lt, ltu;
    logic [31:0] target;
    logic        accept;

    alu u_alu (
        .op1_i          (alu_operand1_i),
        .op2_i          (alu_operand2_i),
        .op_i           (alu_op_i),
        .sub_i          (alu_sub_i),
        .shift_left_i   (alu_shift_left_i),
        .signed_shift_i (alu_signed_shift_i),
        .result_o       (alu_result)
    );

    assign eq  = (alu_operand1_i == alu_operand2_i);
    assign lt  = ($signed(alu_operand1_i) < $signed(alu_operand2_i));
    assign ltu = (alu_operand1_i < alu_operand2_i);

    always_comb begin
        taken = 1'b0;
        unique case (branch_cond_i)
            NO_BRANCH:     taken = 1'b0;
            BRANCH_UNCOND: taken = 1'b1;
            BRANCH_BEQ:    taken = eq;
            BRANCH_BNE:    taken = !eq;
            BRANCH_BLT:    taken = lt;
            BRANCH_BGE:    taken = !lt;
            BRANCH_BLTU:   taken = ltu;
            BRANCH_BGEU:   taken = !ltu;
            default:       taken = 1'b0;
        endcase
    end

    // Offset is in half-words; append the implicit zero and sign-extend.
    assign target = pc_i + {{11{branch_offset_i[19]}}, branch_offset_i, 1'b0};

    assign input_ready_o = !output_valid_o || output_ready_i;
    assign accept        = input_valid_i && input_ready_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            output_valid_o     <= 1'b0;
            result_o           <= '0;
            reg_write_o        <= 1'b0;
            reg_addr_o         <= '0;
            ls_enable_o        <= 1'b0;
            ls_write_o         <= 1'b0;
            ls_write_data_o    <= '0;
            ls_sel_o           <= '0;
            ls_unsigned_load_o <= 1'b0;
            branch_o           <= 1'b0;
            branch_target_o    <= '0;
        end else if (accept) begin
            output_valid_o     <= 1'b1;
            result_o           <= alu_result;
            reg_write_o        <= reg_write_i;
            reg_addr_o         <= reg_addr_i;
            ls_enable_o        <= ls_enable_i;
            ls_write_o         <= ls_write_i;
            ls_write_data_o    <= ls_write_data_i;
            ls_sel_o           <= ls_sel_i;
            ls_unsigned_load_o <= ls_unsigned_load_i;
            branch_o           <= taken;
            branch_target_o    <= target;
        end else begin
            // Redirect pulses only on the first cycle, even if stalled.
            branch_o <= 1'b0;
            if (output_ready_i) begin
                output_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for the execute stage: vector table plus handshake,
// stall, streaming and reset sequences.
module tb_execute;
    import ecap5_dproc_pkg::*;

    logic        clk, rst;
    logic        input_ready, input_valid;
    logic [31:0] pc, op1, op2;
    logic [2:0]  alu_op, cond;
    logic        sub, shl, sshift;
    logic [19:0] offset;
    logic        reg_write, ls_enable, ls_write, ls_unsigned;
    logic [4:0]  reg_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_sel;
    logic        output_ready, output_valid;
    logic [31:0] result;
    logic        reg_write_q, ls_enable_q, ls_write_q, ls_unsigned_q;
    logic [4:0]  reg_addr_q;
    logic [31:0] ls_wdata_q;
    logic [3:0]  ls_sel_q;
    logic        branch;
    logic [31:0] branch_target;

    int errors = 0;
    int checks = 0;

    execute dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .input_ready_o      (input_ready),
        .input_valid_i      (input_valid),
        .pc_i               (pc),
        .alu_operand1_i     (op1),
        .alu_operand2_i     (op2),
        .alu_op_i           (alu_op),
        .alu_sub_i          (sub),
        .alu_shift_left_i   (shl),
        .alu_signed_shift_i (sshift),
        .branch_cond_i      (cond),
        .branch_offset_i    (offset),
        .reg_write_i        (reg_write),
        .reg_addr_i         (reg_addr),
        .ls_enable_i        (ls_enable),
        .ls_write_i         (ls_write),
        .ls_write_data_i    (ls_wdata),
        .ls_sel_i           (ls_sel),
        .ls_unsigned_load_i (ls_unsigned),
        .output_ready_i     (output_ready),
        .output_valid_o     (output_valid),
        .result_o           (result),
        .reg_write_o        (reg_write_q),
        .reg_addr_o         (reg_addr_q),
        .ls_enable_o        (ls_enable_q),
        .ls_write_o         (ls_write_q),
        .ls_write_data_o    (ls_wdata_q),
        .ls_sel_o           (ls_sel_q),
        .ls_unsigned_load_o (ls_unsigned_q),
        .branch_o           (branch),
        .branch_target_o    (branch_target)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]  op;
        logic        sub;
        logic        shl;
        logic        ss;
        logic [2:0]  cond;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [19:0] off;
        logic [31:0] res;
        logic        br;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(logic [2:0] op, logic s, logic l, logic ss, logic [2:0] c,
                                logic [31:0] a, logic [31:0] b, logic [31:0] p,
                                logic [19:0] o, logic [31:0] r, logic br, logic [31:0] t);
        vec_t v;
        v.op = op; v.sub = s; v.shl = l; v.ss = ss; v.cond = c;
        v.a = a; v.b = b; v.pc = p; v.off = o; v.res = r; v.br = br; v.tgt = t;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input int idx);
        alu_op = v.op; sub = v.sub; shl = v.shl; sshift = v.ss; cond = v.cond;
        op1 = v.a; op2 = v.b; pc = v.pc; offset = v.off;
        reg_write = idx[0]; ls_enable = idx[1]; ls_write = idx[2]; ls_unsigned = idx[3];
        reg_addr = idx[4:0]; ls_sel = idx[3:0]; ls_wdata = 32'hA500_0000 | 32'(idx);
    endtask

    task automatic drive_add(input logic [31:0] a, input logic [31:0] b);
        drive(mk(ALU_ADD, 0, 0, 0, NO_BRANCH, a, b, 32'h0, 20'h0, 32'h0, 0, 32'h0), 0);
    endtask

    initial begin
        vec_t jmp;
        vecs[0]  = mk(ALU_ADD,  0, 0, 0, NO_BRANCH, 32'hFFFFFFFF, 32'h1, 0, 0, 32'h0, 0, 0);
        vecs[1]  = mk(ALU_ADD,  1, 0, 0, NO_BRANCH, 32'h5, 32'h7, 0, 0, 32'hFFFFFFFE, 0, 0);
        vecs[2]  = mk(ALU_SHR,  0, 0, 1, NO_BRANCH, 32'h80000000, 32'h4, 0, 0,
                      32'hF8000000, 0, 0);
        vecs[3]  = mk(ALU_SHR,  0, 0, 0, NO_BRANCH, 32'h80000000, 32'h4, 0, 0,
                      32'h08000000, 0, 0);
        vecs[4]  = mk(ALU_SLL,  0, 1, 0, NO_BRANCH, 32'h1, 32'h3F, 0, 0, 32'h80000000, 0, 0);
        vecs[5]  = mk(ALU_SLT,  0, 0, 0, NO_BRANCH, 32'hFFFFFFFF, 32'h1, 0, 0, 32'h1, 0, 0);
        vecs[6]  = mk(ALU_SLTU, 0, 0, 0, NO_BRANCH, 32'hFFFFFFFF, 32'h1, 0, 0, 32'h0, 0, 0);
        vecs[7]  = mk(ALU_XOR,  0, 0, 0, NO_BRANCH, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0,
                      32'h0FF00FF0, 0, 0);
        vecs[8]  = mk(ALU_OR,   0, 0, 0, NO_BRANCH, 32'hF0F0F0F0, 32'h0F0F0000, 0, 0,
                      32'hFFFFF0F0, 0, 0);
        vecs[9]  = mk(ALU_AND,  0, 0, 0, NO_BRANCH, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0,
                      32'hF000F000, 0, 0);
        vecs[10] = mk(ALU_ADD,  0, 0, 0, BRANCH_BLT, 32'hFFFFFFFF, 32'h1, 32'h100, 20'hFFFFC,
                      32'h0, 1, 32'h000000F8);
        vecs[11] = mk(ALU_ADD,  0, 0, 0, BRANCH_BLTU, 32'hFFFFFFFF, 32'h1, 32'h100, 20'hFFFFC,
                      32'h0, 0, 0);
        vecs[12] = mk(ALU_ADD,  0, 0, 0, BRANCH_BEQ, 32'h5, 32'h5, 32'h1000, 20'h00010,
                      32'hA, 1, 32'h1020);
        vecs[13] = mk(ALU_ADD,  0, 0, 0, BRANCH_BNE, 32'h5, 32'h5, 32'h1000, 20'h00010,
                      32'hA, 0, 0);
        vecs[14] = mk(ALU_ADD,  0, 0, 0, BRANCH_BGE, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFF0,
                      20'h00010, 32'h0, 1, 32'h00000010);
        vecs[15] = mk(ALU_ADD,  0, 0, 0, BRANCH_BGEU, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFF0,
                      20'h00010, 32'h0, 0, 0);
        vecs[16] = mk(ALU_ADD,  0, 0, 0, BRANCH_UNCOND, 32'h200, 32'h4, 32'h200, 20'h7FFFF,
                      32'h204, 1, 32'h001001FE);

        rst = 1'b0; input_valid = 1'b0; output_ready = 1'b1;
        drive_add(32'h0, 32'h0);
        #3;
        check("reset valid", 32'(output_valid), 32'h0);
        check("reset branch", 32'(branch), 32'h0);
        check("reset result", result, 32'h0);
        check("reset passthru", {reg_write_q, reg_addr_q, ls_enable_q, ls_write_q, ls_sel_q,
                                 ls_unsigned_q, ls_wdata_q[17:0]}, 32'h0);
        check("reset target", branch_target, 32'h0);
        check("reset input_ready", 32'(input_ready), 32'h1);
        @(negedge clk);
        rst = 1'b1;

        // Table vectors, each followed by one idle cycle.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vecs[i], i);
            input_valid = 1'b1;
            @(posedge clk);
            #1;
            input_valid = 1'b0;
            check($sformatf("v%0d valid", i), 32'(output_valid), 32'h1);
            check($sformatf("v%0d result", i), result, vecs[i].res);
            check($sformatf("v%0d branch", i), 32'(branch), 32'(vecs[i].br));
            if (vecs[i].br) check($sformatf("v%0d target", i), branch_target, vecs[i].tgt);
            check($sformatf("v%0d passthru", i),
                  {reg_write_q, ls_enable_q, ls_write_q, ls_unsigned_q, reg_addr_q, ls_sel_q},
                  {i[0], i[1], i[2], i[3], i[4:0], i[3:0]});
            check($sformatf("v%0d wdata", i), ls_wdata_q, 32'hA500_0000 | 32'(i));
            @(posedge clk);
            #1;
            check($sformatf("v%0d drain valid", i), 32'(output_valid), 32'h0);
            check($sformatf("v%0d drain branch", i), 32'(branch), 32'h0);
        end

        // Taken JUMP held by a 3-cycle downstream stall.
        jmp = mk(ALU_ADD, 0, 0, 0, BRANCH_UNCOND, 32'h300, 32'h4, 32'h300, 20'h00008,
                 32'h304, 1, 32'h310);
        @(negedge clk);
        drive(jmp, 0);
        input_valid = 1'b1;
        output_ready = 1'b0;
        @(posedge clk);
        #1;
        check("stall c0 branch", 32'(branch), 32'h1);
        check("stall c0 result", result, 32'h304);
        check("stall c0 target", branch_target, 32'h310);
        check("stall c0 input_ready", 32'(input_ready), 32'h0);
        drive_add(32'h999, 32'h1);
        for (int c = 1; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall c%0d valid", c), 32'(output_valid), 32'h1);
            check($sformatf("stall c%0d branch", c), 32'(branch), 32'h0);
            check($sformatf("stall c%0d result", c), result, 32'h304);
            check($sformatf("stall c%0d target", c), branch_target, 32'h310);
            check($sformatf("stall c%0d input_ready", c), 32'(input_ready), 32'h0);
        end
        @(negedge clk);
        input_valid = 1'b0;
        output_ready = 1'b1;
        #1;
        check("stall release input_ready", 32'(input_ready), 32'h1);
        @(posedge clk);
        #1;
        check("stall drained", 32'(output_valid), 32'h0);
        check("stall target held", branch_target, 32'h310);

        // Back-to-back stream of 8 with no bubbles.
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check($sformatf("stream %0d valid", i - 1), 32'(output_valid), 32'h1);
                check($sformatf("stream %0d result", i - 1), result, 32'((i - 1) * 3 + 100));
            end
            if (i < 8) begin
                drive_add(32'(i * 3), 32'd100);
                input_valid = 1'b1;
            end else begin
                input_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("stream end valid", 32'(output_valid), 32'h0);

        // Asynchronous reset in the middle of a stall.
        @(negedge clk);
        drive(jmp, 0);
        input_valid = 1'b1;
        output_ready = 1'b0;
        @(posedge clk);
        #1;
        check("rst pre branch", 32'(branch), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("rst async valid", 32'(output_valid), 32'h0);
        check("rst async branch", 32'(branch), 32'h0);
        check("rst async result", result, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        output_ready = 1'b1;
        drive_add(32'h2, 32'h3);
        input_valid = 1'b1;
        @(posedge clk);
        #1;
        input_valid = 1'b0;
        check("post rst valid", 32'(output_valid), 32'h1);
        check("post rst result", result, 32'h5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
